// File: rtl/lynx_pkg.sv
// Shared types for the boot-copy engine: FSM state encoding and tick-counter width.
package lynx_pkg;
  localparam int TCW = 3;

  typedef enum logic [3:0] {
    IDLE, ADDR, FETCH, WRITE, HOLD, VFY_ADDR, VFY_FETCH, VFY_READ, VFY_CMP, DONE
  } state_t;
endpackage

// File: rtl/ram_loader_if.sv
// ROM/RAM/status bundle between the boot loader (master) and the memory side (slave).
interface ram_loader_if #(
  parameter int AW = 21,
  parameter int SW = 14
);
  logic          ready;
  logic [2:0]    srcSel;
  logic [SW-1:0] srcA;
  logic [7:0]    srcQ;
  logic [AW-1:0] ramA;
  logic [7:0]    ramD;
  logic          ramWe;
  logic          ramRd;
  logic [7:0]    ramQ;
  logic          done;
  logic          err;
  logic [AW-1:0] errA;

  modport master (
    input  ready, srcQ, ramQ,
    output srcSel, srcA, ramA, ramD, ramWe, ramRd, done, err, errA
  );

  modport slave (
    output ready, srcQ, ramQ,
    input  srcSel, srcA, ramA, ramD, ramWe, ramRd, done, err, errA
  );
endinterface

// File: rtl/ldr_timer.sv
// ce-gated loadable down-counter with zero flag; freeze holds the count (used for ready stalls).
module ldr_timer
  import lynx_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  input  logic           load,
  input  logic           freeze,
  input  logic [TCW-1:0] loadVal,
  output logic           zero
);
  logic [TCW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (ce) begin
      if (load)                     cnt <= loadVal;
      else if (!freeze && !zero)    cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/ram_loader.sv
// Boot-copy engine: copies IMAGES ROM images into external RAM, optional readback verify.
// Per byte 2+SRCLAT+WAIT ce ticks; ready low freezes address/fetch, strobes always complete.
module ram_loader
  import lynx_pkg::*;
#(
  parameter int            AW     = 21,
  parameter int            SW     = 14,
  parameter int            IMAGES = 2,
  parameter logic [AW-1:0] BASE   = '0,
  parameter int            SRCLAT = 1,
  parameter int            WAIT   = 2,
  parameter int            RDLAT  = 2,
  parameter int            VERIFY = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  ram_loader_if.master  bus
);
  state_t         state, stateNext;
  logic [SW-1:0]  offset, offNext, offInc;
  logic [2:0]     image, imgNext;
  logic [3:0]     imgInc;
  logic           lastByte, loadAddr;
  logic           tLoad, tFreeze, tZero;
  logic [TCW-1:0] tVal;
  logic [7:0]     expQ, gotQ;

  function automatic logic [AW-1:0] destAddr(input logic [2:0] img, input logic [SW-1:0] off);
    return BASE + (AW'(img) << SW) + AW'(off);
  endfunction

  ldr_timer u_timer (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .load    (tLoad),
    .freeze  (tFreeze),
    .loadVal (tVal),
    .zero    (tZero)
  );

  assign offInc   = offset + 1'b1;
  assign imgInc   = {1'b0, image} + ((offInc == '0) ? 4'd1 : 4'd0);
  assign lastByte = (imgInc == 4'(IMAGES));

  always_comb begin
    stateNext = state;
    loadAddr  = 1'b0;
    offNext   = offset;
    imgNext   = image;
    tLoad     = 1'b0;
    tVal      = '0;
    tFreeze   = 1'b0;
    case (state)
      IDLE: if (bus.ready) begin
        stateNext = ADDR;
        loadAddr  = 1'b1;
        offNext   = '0;
        imgNext   = '0;
      end
      ADDR: if (bus.ready) begin
        stateNext = FETCH;
        tLoad     = 1'b1;
        tVal      = TCW'(SRCLAT - 1);
      end
      FETCH: begin
        tFreeze = !bus.ready;
        if (bus.ready && tZero) begin
          stateNext = WRITE;
          tLoad     = 1'b1;
          tVal      = TCW'(WAIT - 1);
        end
      end
      WRITE: if (tZero) stateNext = HOLD;
      // Shared NEXT decision for the copy and verify passes.
      HOLD, VFY_CMP: if (bus.ready) begin
        loadAddr = 1'b1;
        offNext  = offInc;
        imgNext  = imgInc[2:0];
        if (!lastByte) begin
          stateNext = (state == HOLD) ? ADDR : VFY_ADDR;
        end else if (state == HOLD && VERIFY != 0) begin
          stateNext = VFY_ADDR;
          offNext   = '0;
          imgNext   = '0;
        end else begin
          stateNext = DONE;
          loadAddr  = 1'b0;
        end
      end
      VFY_ADDR: if (bus.ready) begin
        stateNext = VFY_FETCH;
        tLoad     = 1'b1;
        tVal      = TCW'(SRCLAT - 1);
      end
      VFY_FETCH: begin
        tFreeze = !bus.ready;
        if (bus.ready && tZero) begin
          stateNext = VFY_READ;
          tLoad     = 1'b1;
          tVal      = TCW'(RDLAT - 1);
        end
      end
      VFY_READ: if (tZero) stateNext = VFY_CMP;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      offset     <= '0;
      image      <= '0;
      bus.srcA   <= '0;
      bus.srcSel <= '0;
      bus.ramA   <= '0;
      bus.ramD   <= '0;
      bus.err    <= 1'b0;
      bus.errA   <= '0;
      expQ       <= '0;
      gotQ       <= '0;
    end else if (ce) begin
      state <= stateNext;
      if (loadAddr) begin
        offset     <= offNext;
        image      <= imgNext;
        bus.srcA   <= offNext;
        bus.srcSel <= imgNext;
        bus.ramA   <= destAddr(imgNext, offNext);
      end
      if (state == FETCH && bus.ready && tZero)     bus.ramD <= bus.srcQ;
      if (state == VFY_FETCH && bus.ready && tZero) expQ     <= bus.srcQ;
      if (state == VFY_READ && tZero)               gotQ     <= bus.ramQ;
      if (state == VFY_CMP && gotQ != expQ && !bus.err) begin
        bus.err  <= 1'b1;
        bus.errA <= bus.ramA;
      end
    end
  end

  assign bus.ramWe = (state != WRITE);
  assign bus.ramRd = (state != VFY_READ);
  assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: copy timing, ce gating, ready stall, abort, verify and wrap.
module tb_ram_loader;
  localparam int AW   = 21;
  localparam int SW   = 4;
  localparam int WAIT = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstN [3];
  logic ceS  [3];
  logic rdy  [3];
  logic clrA = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;
  int   sel    = 0;
  int   cePer  = 1;
  int   abortReq = 0, abortSeen = 0;
  int   bothLow = 0, rdLow = 0;
  logic [AW+7:0] expQ [$];
  logic [7:0] memA [256];
  logic [7:0] memV [256];
  logic [7:0] memW [256];

  ram_loader_if #(.AW(AW), .SW(SW)) busA ();
  ram_loader_if #(.AW(AW), .SW(SW)) busV ();
  ram_loader_if #(.AW(AW), .SW(SW)) busW ();

  ram_loader #(.AW(AW), .SW(SW), .IMAGES(2), .BASE(21'h000100)) dutA
    (.clock(clock), .reset(rstN[0]), .ce(ceS[0]), .bus(busA));
  ram_loader #(.AW(AW), .SW(SW), .IMAGES(2), .BASE(21'h000100), .VERIFY(1)) dutV
    (.clock(clock), .reset(rstN[1]), .ce(ceS[1]), .bus(busV));
  ram_loader #(.AW(AW), .SW(SW), .IMAGES(1), .BASE(21'h1FFFF8)) dutW
    (.clock(clock), .reset(rstN[2]), .ce(ceS[2]), .bus(busW));

  function automatic logic [7:0] romByte(input logic [2:0] img, input logic [3:0] off);
    return {img, 1'b0, off} ^ 8'hA5;
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // ROM (one-tick latency) and RAM models; V corrupts readback of two addresses
  assign busA.ready = rdy[0];
  assign busV.ready = rdy[1];
  assign busW.ready = rdy[2];
  assign busA.ramQ  = memA[busA.ramA[7:0]];
  assign busW.ramQ  = memW[busW.ramA[7:0]];
  assign busV.ramQ  = memV[busV.ramA[7:0]] ^
                      ((busV.ramA == 21'h107 || busV.ramA == 21'h115) ? 8'h3C : 8'h00);

  always @(posedge clock) begin
    if (ceS[0]) busA.srcQ <= romByte(busA.srcSel, busA.srcA);
    if (ceS[1]) busV.srcQ <= romByte(busV.srcSel, busV.srcA);
    if (ceS[2]) busW.srcQ <= romByte(busW.srcSel, busW.srcA);
    if (clrA) memA <= '{default: 8'h00};
    else if (ceS[0] && !busA.ramWe) memA[busA.ramA[7:0]] <= busA.ramD;
    if (ceS[1] && !busV.ramWe) memV[busV.ramA[7:0]] <= busV.ramD;
    if (ceS[2] && !busW.ramWe) memW[busW.ramA[7:0]] <= busW.ramD;
  end

  logic          monWe, monRd, monDone;
  logic [AW-1:0] monA;
  logic [7:0]    monD;
  assign monWe   = (sel == 1) ? busV.ramWe : (sel == 2) ? busW.ramWe : busA.ramWe;
  assign monRd   = (sel == 1) ? busV.ramRd : (sel == 2) ? busW.ramRd : busA.ramRd;
  assign monDone = (sel == 1) ? busV.done  : (sel == 2) ? busW.done  : busA.done;
  assign monA    = (sel == 1) ? busV.ramA  : (sel == 2) ? busW.ramA  : busA.ramA;
  assign monD    = (sel == 1) ? busV.ramD  : (sel == 2) ? busW.ramD  : busA.ramD;

  // Monitor: one scoreboard entry per completed write strobe
  logic          inW = 1'b0, stable;
  int            wlen;
  logic [AW-1:0] wA;
  logic [7:0]    wD;
  logic [AW+7:0] ent;
  always @(negedge clock) begin
    if (!monWe && !monRd) bothLow++;
    if (!monRd) rdLow++;
    if (!monWe) begin
      if (!inW) begin
        inW = 1'b1; wlen = 1; wA = monA; wD = monD; stable = 1'b1;
      end else begin
        wlen++;
        if (monA !== wA || monD !== wD) stable = 1'b0;
      end
    end else if (inW) begin
      inW = 1'b0;
      if (abortReq != abortSeen) begin
        abortSeen++;
      end else if (expQ.size() == 0) begin
        check("wrUnexpected", {11'h0, wA}, 32'hFFFFFFFF);
      end else begin
        ent = expQ.pop_front();
        check("wrAddr", 32'(wA), 32'(ent[AW+7:8]));
        check("wrData", 32'(wD), 32'(ent[7:0]));
        check("wrLen", wlen, WAIT * cePer);
        check("wrStable", 32'(stable), 32'd1);
      end
    end
  end

  task automatic pushImages(input logic [AW-1:0] base, input int images);
    for (int img = 0; img < images; img++)
      for (int off = 0; off < 16; off++)
        expQ.push_back({base + AW'(img * 16 + off), romByte(3'(img), 4'(off))});
  endtask

  // Releases reset of one instance and counts clocks until done (-1 on timeout).
  task automatic runDut(input int which, input int per, input int stallByte,
                        input int abortByte, output int doneCyc);
    int            stallCnt = 0;
    bit            stallArmed, abortArmed, abortPend = 0;
    logic [AW-1:0] sA;
    logic [7:0]    sD;
    stallArmed = (stallByte >= 0);
    abortArmed = (abortByte >= 0);
    sel = which;
    cePer = per;
    doneCyc = -1;
    rstN[which] = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      ceS[which] = (n % per == 0);
      @(posedge clock); #1;
      if (monDone) begin doneCyc = n; break; end
      if (stallArmed && !monWe && monA[7:0] == 8'(stallByte)) begin
        stallArmed = 0;
        stallCnt = 11;
      end else if (stallCnt > 0) begin
        stallCnt--;
        rdy[which] = (stallCnt == 0);
        if (stallCnt == 10) begin sA = monA; sD = monD; end
        if (stallCnt == 0) begin
          check("stallRamA", 32'(monA), 32'(sA));
          check("stallRamD", 32'(monD), 32'(sD));
        end
      end
      if (abortPend) begin
        check("abortWeHigh", 32'(monWe), 32'd1);
        abortPend = 0;
        clrA = 1'b1;
        expQ.delete();
        pushImages(21'h100, 2);
        rstN[which] = 1'b1;
        n = 0;
      end else if (abortArmed && !monWe && monA[7:0] == 8'(abortByte)) begin
        abortArmed = 0;
        abortPend = 1;
        abortReq++;
        rstN[which] = 1'b0;
      end else begin
        clrA = 1'b0;
      end
    end
  endtask

  task automatic resetDut(input int which);
    rstN[which] = 1'b0;
    ceS[which] = 1'b1;
    rdy[which] = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  function automatic int memBadA();
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (memA[i] !== romByte(3'(i / 16), 4'(i % 16))) bad++;
    return bad;
  endfunction

  initial begin
    int dc;
    for (int i = 0; i < 3; i++) begin rstN[i] = 1'b0; ceS[i] = 1'b1; rdy[i] = 1'b1; end
    repeat (3) @(posedge clock);
    #1;
    clrA = 1'b0;
    check("rstRamWe",  32'(busA.ramWe),  32'd1);
    check("rstRamRd",  32'(busA.ramRd),  32'd1);
    check("rstDone",   32'(busA.done),   32'd0);
    check("rstErr",    32'(busA.err),    32'd0);
    check("rstRamA",   32'(busA.ramA),   32'd0);
    check("rstRamD",   32'(busA.ramD),   32'd0);
    check("rstSrcA",   32'(busA.srcA),   32'd0);
    check("rstSrcSel", 32'(busA.srcSel), 32'd0);
    check("rstErrA",   32'(busA.errA),   32'd0);

    pushImages(21'h100, 2);
    runDut(0, 1, -1, -1, dc);
    check("doneCycleCe1", dc, 161);
    check("queueLeft1", expQ.size(), 0);
    check("memAfterCopy", memBadA(), 0);

    resetDut(0);
    check("doneClearedByReset", 32'(busA.done), 32'd0);
    pushImages(21'h100, 2);
    runDut(0, 3, -1, -1, dc);
    check("doneCycleCe3", dc, 483);
    check("queueLeft2", expQ.size(), 0);

    // ready low during the last strobe tick of byte 5; HOLD absorbs the 9 following low ticks
    resetDut(0);
    pushImages(21'h100, 2);
    runDut(0, 1, 5, -1, dc);
    check("doneCycleStall", dc, 161 + 9);
    check("queueLeft3", expQ.size(), 0);

    resetDut(0);
    pushImages(21'h100, 2);
    runDut(0, 1, -1, 8'h13, dc);
    check("doneCycleRestart", dc, 161);
    check("queueLeft4", expQ.size(), 0);
    check("memAfterRestart", memBadA(), 0);

    pushImages(21'h100, 2);
    runDut(1, 1, -1, -1, dc);
    check("vfyDone", 32'(busV.done), 32'd1);
    check("vfyErr",  32'(busV.err),  32'd1);
    check("vfyErrA", 32'(busV.errA), 32'h107);
    check("vfyReadTicks", rdLow, 64);
    check("queueLeft5", expQ.size(), 0);

    pushImages(21'h1FFFF8, 1);
    runDut(2, 1, -1, -1, dc);
    check("doneCycleWrap", dc, 81);
    check("wrapFinalRamA", 32'(busW.ramA), 32'h7);
    check("queueLeft6", expQ.size(), 0);

    check("strobesOverlap", bothLow, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
